// File: rtl/vend_pkg.sv
// Shared types and codes for the vending-machine sequencer: state enum, coin/denomination
// codes and the credit-register input select codes.
package vend_pkg;

  typedef enum logic [3:0] {
    StInit,
    StCredit,
    StChkExc,
    StCost,
    StCheck,
    StPay,
    StDisp,
    StChgLoad,
    StChgOut,
    StFinish
  } state_e;

  localparam logic [1:0] DEN_1  = 2'b00;
  localparam logic [1:0] DEN_2  = 2'b01;
  localparam logic [1:0] DEN_10 = 2'b10;
  localparam logic [1:0] DEN_20 = 2'b11;

  localparam logic [1:0] A_SUM    = 2'b00;
  localparam logic [1:0] A_20     = 2'b10;
  localparam logic [1:0] A_REMAIN = 2'b11;

endpackage

// File: rtl/vend_ctrl.sv
// Sequencing FSM for the vending-machine datapath: coin accept, order check, cup dispense and
// greedy 20/10/2/1 change. Define PRICE_UPDATE_EN to let price_wr reload prices in CREDIT.
module vend_ctrl
  import vend_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       coin_valid,
  input  logic [1:0] coin_sel,
  output logic       coin_ready,
  input  logic       order_valid,
  input  logic       cancel,
  input  logic       price_wr,
  output logic       busy,
  output logic       cup_out,
  output logic       coin_out,
  output logic [1:0] coin_den,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       LD_A,
  output logic       LD_B,
  output logic       LD_C,
  output logic       LD_D,
  output logic       LD_E,
  output logic       LD_CNT,
  output logic       LD_MEM,
  output logic       CD_D,
  output logic       CD_CNT,
  output logic       Sel_DIV_IN,
  output logic [1:0] Sel_A_IN,
  output logic [1:0] Sel_ADD_IN,
  output logic [1:0] Sel_DIVISOR,
  output logic       DP_CLR,
  input  logic       Z,
  input  logic       Z2,
  input  logic       exceed,
  input  logic       ready
);

  state_e     state_q;
  logic [1:0] den_q;

`ifndef PRICE_UPDATE_EN
  logic unused_price_wr;
  assign unused_price_wr = price_wr;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StInit;
      den_q   <= DEN_1;
    end else begin
      unique case (state_q)
        StInit:   state_q <= StCredit;
        StCredit: begin
          if (cancel) begin
            den_q   <= DEN_20;
            state_q <= StChgLoad;
          end else if (order_valid) begin
            state_q <= StCost;
          end else if (coin_valid) begin
            state_q <= StChkExc;
          end
        end
        StChkExc: state_q <= StCredit;
        StCost:   state_q <= StCheck;
        StCheck:  state_q <= ready ? StPay : StCredit;
        StPay: begin
          den_q   <= DEN_20;
          state_q <= StDisp;
        end
        StDisp:    if (Z2) state_q <= StChgLoad;
        StChgLoad: state_q <= StChgOut;
        StChgOut: begin
          if (Z) begin
            if (den_q == DEN_1) begin
              state_q <= StFinish;
            end else begin
              den_q   <= den_q - 2'd1;
              state_q <= StChgLoad;
            end
          end
        end
        StFinish: state_q <= StCredit;
        default:  state_q <= StInit;
      endcase
    end
  end

  always_comb begin
    coin_ready   = 1'b0;
    busy         = (state_q != StCredit);
    cup_out      = 1'b0;
    coin_out     = 1'b0;
    coin_den     = 2'b00;
    coin_reject  = 1'b0;
    insufficient = 1'b0;
    LD_A         = 1'b0;
    LD_B         = 1'b0;
    LD_C         = 1'b0;
    LD_D         = 1'b0;
    LD_E         = 1'b0;
    LD_CNT       = 1'b0;
    LD_MEM       = 1'b0;
    CD_D         = 1'b0;
    CD_CNT       = 1'b0;
    Sel_DIV_IN   = 1'b0;
    Sel_A_IN     = A_SUM;
    Sel_ADD_IN   = 2'b00;
    Sel_DIVISOR  = 2'b00;
    DP_CLR       = 1'b0;
    unique case (state_q)
      StInit: LD_MEM = 1'b1;
      StCredit: begin
        coin_ready = 1'b1;
        if (cancel) begin
          // Change sequence runs from state alone; nothing to load here.
        end else if (order_valid) begin
          LD_C = 1'b1;
          LD_D = 1'b1;
        end else if (coin_valid) begin
          LD_A       = 1'b1;
          Sel_A_IN   = A_SUM;
          Sel_ADD_IN = coin_sel;
`ifdef PRICE_UPDATE_EN
        end else if (price_wr) begin
          LD_MEM = 1'b1;
`endif
        end
      end
      StChkExc: begin
        if (exceed) begin
          LD_A        = 1'b1;
          Sel_A_IN    = A_20;
          coin_reject = 1'b1;
        end
      end
      StCost:  LD_E = 1'b1;
      StCheck: insufficient = ~ready;
      StPay: begin
        LD_A     = 1'b1;
        Sel_A_IN = A_REMAIN;
      end
      StDisp: begin
        if (!Z2) begin
          cup_out = 1'b1;
          CD_D    = 1'b1;
        end
      end
      StChgLoad: begin
        // Largest denomination divides the remaining credit; the rest divide the remainder.
        Sel_DIV_IN  = (den_q == DEN_20);
        Sel_DIVISOR = den_q;
        LD_CNT      = 1'b1;
        LD_B        = 1'b1;
      end
      StChgOut: begin
        if (!Z) begin
          coin_out = 1'b1;
          coin_den = den_q;
          CD_CNT   = 1'b1;
        end
      end
      StFinish: DP_CLR = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Sequencing FSM for the vending-machine datapath. It drives every load, count-down and select line of the datapath and consumes its status flags (Z, Z2, exceed, ready). It takes coin, order and cancel events from the front panel and emits cup-dispense and change-coin pulses. It sits beside the datapath in the top level; the datapath reset is driven as RST | DP_CLR.

## Interface
Parameters: none.

Clock and reset:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high

Front panel:
- coin_valid  in  1  coin present this cycle; accepted only when coin_ready=1
- coin_sel  in  2  coin value: 00=1, 01=2, 10=10, 11=20
- coin_ready  out  1  high only in CREDIT
- order_valid  in  1  order request; Kind and Cups are sampled with it
- cancel  in  1  refund the current credit
- price_wr  in  1  reload prices (requires PRICE_UPDATE_EN)
- busy  out  1  high in every state except CREDIT
- cup_out  out  1  one pulse per cup
- coin_out  out  1  one pulse per change coin
- coin_den  out  2  value of the change coin, same coding as coin_sel; valid with coin_out
- coin_reject  out  1  pulse: credit was clamped to 20
- insufficient  out  1  pulse: order refused

Datapath control (outputs):
- LD_A, LD_B, LD_C, LD_D, LD_E, LD_CNT, LD_MEM  out  1 each  register loads
- CD_D, CD_CNT  out  1 each  count-down enables
- Sel_DIV_IN  out  1  1 selects A, 0 selects B
- Sel_A_IN  out  2  00 = sum, 10 = constant 20, 11 = A−E
- Sel_ADD_IN, Sel_DIVISOR  out  2 each  value coding 1/2/10/20
- DP_CLR  out  1  datapath clear pulse

Datapath status (inputs):
- Z, Z2, exceed, ready  in  1 each

## Operation
- Every output is a registered-state decode. All pulses last one cycle. Control outputs are 0 unless stated.
- Internal register den[1:0] holds the current change denomination.
- Any request not legal in the current state is ignored.
- State behaviour:
  - INIT: LD_MEM=1, then go to CREDIT. Entered on every reset because MEM has no reset.
  - CREDIT: coin_ready=1. Request priority is cancel > order_valid > coin_valid > price_wr.
    - cancel: den←11, go to CHG_LOAD.
    - order_valid: LD_C=1, LD_D=1, go to COST.
    - coin_valid: LD_A=1, Sel_A_IN=00, Sel_ADD_IN=coin_sel, go to CHK_EXC.
    - price_wr (macro only): LD_MEM=1, stay in CREDIT.
  - CHK_EXC: if exceed, LD_A=1 with Sel_A_IN=10 and coin_reject=1. Always return to CREDIT.
  - COST: LD_E=1, go to CHECK. The cost is combinational from C and D, so it becomes valid after LD_C/LD_D.
  - CHECK: if ready, go to PAY. Otherwise insufficient=1 and return to CREDIT; A, C, D and E are kept.
  - PAY: LD_A=1, Sel_A_IN=11, den←11, go to DISP.
  - DISP: if Z2, go to CHG_LOAD. Otherwise cup_out=1, CD_D=1, stay in DISP.
  - CHG_LOAD: Sel_DIV_IN=(den==11), Sel_DIVISOR=den, LD_CNT=1, LD_B=1, go to CHG_OUT.
  - CHG_OUT: if Z, then go to FINISH when den==00, else den←den−1 and go to CHG_LOAD. Otherwise coin_out=1, coin_den=den, CD_CNT=1, stay in CHG_OUT.
  - FINISH: DP_CLR=1 (clears A, B, C, D, E), go to CREDIT.
- The change algorithm is greedy 20/10/2/1. After the den=00 step, B is 0.
- A cancel with A=0 runs the change sequence with zero coins out.
- Arithmetic overflow of the 7-bit cost is the datapath's concern; the controller trusts ready.

## Timing
- Reset: state=INIT and den=00. Every output is 0 except LD_MEM=1 (INIT decode) and busy=1.
- Coin accept: credit is updated at the edge after coin_valid. The exceed clamp lands one cycle later. coin_ready is low for the 1 cycle in CHK_EXC.
- Order to first cup_out: 4 cycles (COST, CHECK, PAY, DISP).
- DISP lasts Cups+1 cycles.
- Each denomination costs 2 + n cycles, where n is the number of coins of that value.
- FINISH is 1 cycle.
- RST at any time aborts the transaction and re-enters INIT. Credit is lost; the top level also resets the datapath.

## Configuration
- PRICE_UPDATE_EN defined: price_wr in CREDIT pulses LD_MEM.
- PRICE_UPDATE_EN undefined: price_wr is unused and LD_MEM pulses only in INIT.

## Structure
- Package vend_pkg contains:
  - the state enum;
  - coin/denomination code localparams (DEN_1=00, DEN_2=01, DEN_10=10, DEN_20=11);
  - Sel_A_IN codes (A_SUM, A_20, A_REMAIN).
- Single module, no sub-module. The FSM is one registered state plus den with a decoded output block.

## Test plan
Test prices: americano=3, ratte=5.
- Purchase with change: coins 10 then 2, order Kind=01 Cups=2 -> 2 cup_out pulses, then 3 coin_out pulses with coin_den=01, then DP_CLR and return to CREDIT.
- Overflow: coins 20 then 1 -> A=21, exceed, coin_reject, A=20. The order ratte×4 then dispenses 4 cups with no change coins.
- Insufficient credit: coin 2, order Kind=10 Cups=1 -> insufficient pulse, back in CREDIT with A=2. A following coin 10 then order succeeds with change 7 (coins 2, 2, 2, 1).
- Cancel: coins 10, 2, 1 then cancel -> coin_out with coin_den 10, 01, 00 in that order, no cup_out.
- Reset mid-operation: RST during DISP of a 3-cup order after 1 cup -> INIT, LD_MEM pulse, no further cup_out.
- Price update: with PRICE_UPDATE_EN, set americano_price=4, pulse price_wr, then buy 1 cup with coin 10 -> change 6. Without the macro the same stimulus gives change 7.
